// File: rtl/datapath_pkg.sv
// Shared MIPS datapath declarations: field types, opcodes and control-select encodings.
package mips_decls_p;

    typedef logic [5:0] opcode_t;
    typedef logic [5:0] funct_t;

    localparam opcode_t OP_RTYPE = 6'b000000;
    localparam opcode_t OP_J     = 6'b000010;
    localparam opcode_t OP_BEQ   = 6'b000100;
    localparam opcode_t OP_ADDI  = 6'b001000;
    localparam opcode_t OP_LW    = 6'b100011;
    localparam opcode_t OP_SW    = 6'b101011;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALURES = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/datapath_regfile.sv
// 32x32 register file: two combinational read ports, one synchronous write port, R0 fixed at zero.
module regfile (
    input  logic        clk,
    input  logic        i_we,
    input  logic [4:0]  i_ra1,
    input  logic [4:0]  i_ra2,
    input  logic [4:0]  i_wa,
    input  logic [31:0] i_wd,
    output logic [31:0] o_rd1,
    output logic [31:0] o_rd2
);

    logic [31:0] r_mem [32];

    // Contents are intentionally not reset; reads of R0 are forced to zero instead.
    always_ff @(posedge clk) begin
        if (i_we && (i_wa != 5'd0))
            r_mem[i_wa] <= i_wd;
    end

    assign o_rd1 = (i_ra1 == 5'd0) ? '0 : r_mem[i_ra1];
    assign o_rd2 = (i_ra2 == 5'd0) ? '0 : r_mem[i_ra2];

endmodule

// File: rtl/datapath.sv
// Multicycle MIPS datapath: architectural state, holding registers, ALU and muxes driven by the controller.
module datapath
    import mips_decls_p::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        pcen,
    input  logic        irwrite,
    input  logic        regwrite,
    input  logic        alusrca,
    input  logic        iord,
    input  logic        memtoreg,
    input  logic        regdst,
    input  logic [1:0]  alusrcb,
    input  logic [1:0]  pcsrc,
    input  logic [2:0]  alucontrol,
    input  logic [31:0] readdata,
    output logic [31:0] adr,
    output logic [31:0] writedata,
    output opcode_t     opcode,
    output funct_t      funct,
    output logic        zero
);

    logic [31:0] r_pc, r_ir, r_data, r_a, r_b, r_aluout;
    logic [31:0] w_rd1, w_rd2, w_signimm, w_srca, w_srcb, w_aluresult, w_pcnext, w_wd3;
    logic [4:0]  w_wa3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc     <= '0;
            r_ir     <= '0;
            r_data   <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_aluout <= '0;
        end else begin
            if (pcen)
                r_pc <= w_pcnext;
            if (irwrite)
                r_ir <= readdata;
            r_data   <= readdata;
            r_a      <= w_rd1;
            r_b      <= w_rd2;
            r_aluout <= w_aluresult;
        end
    end

    assign w_wa3 = regdst ? r_ir[15:11] : r_ir[20:16];
    assign w_wd3 = memtoreg ? r_data : r_aluout;

    // Write is suppressed while reset is high so an abandoned instruction cannot commit.
    regfile u_regfile (
        .clk   (clk),
        .i_we  (regwrite & ~reset),
        .i_ra1 (r_ir[25:21]),
        .i_ra2 (r_ir[20:16]),
        .i_wa  (w_wa3),
        .i_wd  (w_wd3),
        .o_rd1 (w_rd1),
        .o_rd2 (w_rd2)
    );

    assign w_signimm = sign_ext16(r_ir[15:0]);
    assign w_srca    = alusrca ? r_a : r_pc;

    always_comb begin
        w_srcb = r_b;
        case (alusrcb)
            SRCB_B:       w_srcb = r_b;
            SRCB_FOUR:    w_srcb = 32'd4;
            SRCB_IMM:     w_srcb = w_signimm;
            SRCB_IMM_SH2: w_srcb = {w_signimm[29:0], 2'b00};
            default:      w_srcb = r_b;
        endcase
    end

    always_comb begin
        w_aluresult = '0;
        case (alucontrol)
            ALU_ADD: w_aluresult = w_srca + w_srcb;
            ALU_SUB: w_aluresult = w_srca - w_srcb;
            ALU_AND: w_aluresult = w_srca & w_srcb;
            ALU_OR:  w_aluresult = w_srca | w_srcb;
            ALU_SLT: w_aluresult = ($signed(w_srca) < $signed(w_srcb)) ? 32'd1 : 32'd0;
            default: w_aluresult = '0;
        endcase
    end

    always_comb begin
        w_pcnext = w_aluresult;
        case (pcsrc)
            PCSRC_ALUOUT: w_pcnext = r_aluout;
            PCSRC_JUMP:   w_pcnext = {r_pc[31:28], r_ir[25:0], 2'b00};
            default:      w_pcnext = w_aluresult;
        endcase
    end

    assign adr       = iord ? r_aluout : r_pc;
    assign writedata = r_b;
    assign opcode    = r_ir[31:26];
    assign funct     = r_ir[5:0];
    assign zero      = (w_aluresult == '0);

endmodule

// File: tb/tb_datapath.sv
// Directed self-checking bench for the multicycle MIPS datapath.
module tb_datapath;
    import mips_decls_p::*;

    logic        clk, reset, pcen, irwrite, regwrite, alusrca, iord, memtoreg, regdst;
    logic [1:0]  alusrcb, pcsrc;
    logic [2:0]  alucontrol;
    logic [31:0] readdata, adr, writedata;
    opcode_t     opcode;
    funct_t      funct;
    logic        zero;

    int n_tests = 0;
    int n_fail  = 0;

    datapath dut (
        .clk(clk), .reset(reset), .pcen(pcen), .irwrite(irwrite), .regwrite(regwrite),
        .alusrca(alusrca), .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .readdata(readdata),
        .adr(adr), .writedata(writedata), .opcode(opcode), .funct(funct), .zero(zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pcen = 0; irwrite = 0; regwrite = 0; alusrca = 0; iord = 0; memtoreg = 0;
        regdst = 0; alusrcb = SRCB_B; pcsrc = PCSRC_ALURES; alucontrol = ALU_ADD;
    endtask

    task automatic load_ir(input logic [31:0] word);
        readdata = word;
        irwrite  = 1;
        tick();
        irwrite  = 0;
    endtask

    task automatic set_reg(input logic [4:0] idx, input logic [31:0] val);
        load_ir({OP_LW, idx, idx, 16'h0000});
        readdata = val;
        tick();
        memtoreg = 1; regwrite = 1; regdst = 0;
        tick();
        regwrite = 0; memtoreg = 0;
    endtask

    task automatic test_reset();
        reset = 1; readdata = '0; idle();
        #2;
        n_tests++; if (adr !== 32'h0) begin $display("FAIL reset_adr got=%h exp=%h", adr, 32'h0); n_fail++; end
        n_tests++; if (opcode !== 6'b0) begin $display("FAIL reset_opcode got=%b exp=%b", opcode, 6'b0); n_fail++; end
        n_tests++; if (writedata !== 32'h0) begin $display("FAIL reset_writedata got=%h exp=%h", writedata, 32'h0); n_fail++; end
        tick();
        reset = 0;
    endtask

    task automatic test_reset_during_op();
        readdata = 32'h20080005; pcen = 1; irwrite = 1; alusrcb = SRCB_FOUR;
        tick();
        readdata = 32'h2008FFFD;
        tick();
        idle(); alusrcb = SRCB_IMM;
        tick();
        #1;
        n_tests++; if (adr !== 32'h8) begin $display("FAIL pre_reset_pc got=%h exp=%h", adr, 32'h8); n_fail++; end
        iord = 1; #1;
        n_tests++; if (adr !== 32'h5) begin $display("FAIL pre_reset_aluout got=%h exp=%h", adr, 32'h5); n_fail++; end
        reset = 1; #1;
        n_tests++; if (adr !== 32'h0) begin $display("FAIL async_reset_aluout got=%h exp=%h", adr, 32'h0); n_fail++; end
        iord = 0; #1;
        n_tests++; if (adr !== 32'h0) begin $display("FAIL async_reset_pc got=%h exp=%h", adr, 32'h0); n_fail++; end
        n_tests++; if (opcode !== 6'b0 || funct !== 6'b0) begin
            $display("FAIL async_reset_ir got=%b/%b exp=%b/%b", opcode, funct, 6'b0, 6'b0); n_fail++; end
        tick();
        reset = 0;
    endtask

    task automatic test_fetch();
        idle();
        readdata = 32'h20080005; irwrite = 1; pcen = 1; alusrca = 0;
        alusrcb = SRCB_FOUR; alucontrol = ALU_ADD; pcsrc = PCSRC_ALURES;
        tick();
        idle();
        #1;
        n_tests++; if (adr !== 32'h4) begin $display("FAIL fetch_pc got=%h exp=%h", adr, 32'h4); n_fail++; end
        n_tests++; if (opcode !== OP_ADDI) begin $display("FAIL fetch_opcode got=%b exp=%b", opcode, OP_ADDI); n_fail++; end
        n_tests++; if (funct !== 6'h05) begin $display("FAIL fetch_funct got=%h exp=%h", funct, 6'h05); n_fail++; end
        iord = 1; #1;
        n_tests++; if (adr !== 32'h4) begin $display("FAIL fetch_aluout got=%h exp=%h", adr, 32'h4); n_fail++; end
        iord = 0;
    endtask

    task automatic test_writeback();
        tick();
        alusrca = 1; alusrcb = SRCB_IMM; alucontrol = ALU_ADD;
        tick();
        iord = 1; #1;
        n_tests++; if (adr !== 32'h5) begin $display("FAIL addi_exec got=%h exp=%h", adr, 32'h5); n_fail++; end
        regwrite = 1; regdst = 0; memtoreg = 0;
        tick();
        idle();
        load_ir(32'h01080020);
        tick();
        n_tests++; if (writedata !== 32'h5) begin $display("FAIL readback_b got=%h exp=%h", writedata, 32'h5); n_fail++; end
        alusrca = 1; alusrcb = SRCB_FOUR; alucontrol = ALU_ADD;
        tick();
        iord = 1; #1;
        n_tests++; if (adr !== 32'h9) begin $display("FAIL readback_a got=%h exp=%h", adr, 32'h9); n_fail++; end
        idle();
        load_ir(32'h20000007);
        tick();
        alusrca = 1; alusrcb = SRCB_IMM; alucontrol = ALU_ADD;
        tick();
        iord = 1; #1;
        n_tests++; if (adr !== 32'h7) begin $display("FAIL r0_exec got=%h exp=%h", adr, 32'h7); n_fail++; end
        regwrite = 1;
        tick();
        idle();
        load_ir(32'h0);
        tick();
        n_tests++; if (writedata !== 32'h0) begin $display("FAIL r0_b got=%h exp=%h", writedata, 32'h0); n_fail++; end
        alusrca = 1; alusrcb = SRCB_B; alucontrol = ALU_OR; #1;
        n_tests++; if (zero !== 1'b1) begin $display("FAIL r0_a_zero got=%b exp=%b", zero, 1'b1); n_fail++; end
        idle();
    endtask

    task automatic test_rf_old_value();
        set_reg(5'd10, 32'h11);
        load_ir({OP_LW, 5'd10, 5'd10, 16'h0});
        readdata = 32'h22;
        tick();
        n_tests++; if (writedata !== 32'h11) begin $display("FAIL rf_before got=%h exp=%h", writedata, 32'h11); n_fail++; end
        memtoreg = 1; regwrite = 1;
        tick();
        regwrite = 0; memtoreg = 0;
        n_tests++; if (writedata !== 32'h11) begin $display("FAIL rf_same_edge_old got=%h exp=%h", writedata, 32'h11); n_fail++; end
        tick();
        n_tests++; if (writedata !== 32'h22) begin $display("FAIL rf_after got=%h exp=%h", writedata, 32'h22); n_fail++; end
    endtask

    task automatic test_branch_compare();
        set_reg(5'd1, 32'h1234);
        set_reg(5'd2, 32'h1234);
        set_reg(5'd3, 32'h1235);
        load_ir({OP_BEQ, 5'd1, 5'd2, 16'h0});
        tick();
        alusrca = 1; alusrcb = SRCB_B; alucontrol = ALU_SUB; #1;
        n_tests++; if (zero !== 1'b1) begin $display("FAIL beq_equal got=%b exp=%b", zero, 1'b1); n_fail++; end
        load_ir({OP_BEQ, 5'd1, 5'd3, 16'h0});
        tick();
        n_tests++; if (zero !== 1'b0) begin $display("FAIL beq_differ got=%b exp=%b", zero, 1'b0); n_fail++; end
        idle();
    endtask

    task automatic test_slt_and_rtype();
        set_reg(5'd4, 32'hFFFFFFFF);
        set_reg(5'd5, 32'h00000001);
        load_ir({OP_RTYPE, 5'd4, 5'd5, 5'd0, 5'd0, 6'h2A});
        tick();
        alusrca = 1; alusrcb = SRCB_B; alucontrol = ALU_SLT;
        tick();
        iord = 1; #1;
        n_tests++; if (adr !== 32'h1) begin $display("FAIL slt_neg_lt_pos got=%h exp=%h", adr, 32'h1); n_fail++; end
        alucontrol = 3'b011; #1;
        n_tests++; if (zero !== 1'b1) begin $display("FAIL alu_011_zero got=%b exp=%b", zero, 1'b1); n_fail++; end
        load_ir({OP_RTYPE, 5'd5, 5'd4, 5'd0, 5'd0, 6'h2A});
        tick();
        alucontrol = ALU_SLT;
        tick();
        n_tests++; if (adr !== 32'h0) begin $display("FAIL slt_pos_lt_neg got=%h exp=%h", adr, 32'h0); n_fail++; end
        alucontrol = ALU_SUB;
        tick();
        n_tests++; if (adr !== 32'h2) begin $display("FAIL sub_wrap got=%h exp=%h", adr, 32'h2); n_fail++; end
        idle();
        load_ir({OP_RTYPE, 5'd1, 5'd3, 5'd12, 5'd0, 6'h24});
        tick();
        alusrca = 1; alusrcb = SRCB_B; alucontrol = ALU_AND;
        tick();
        regwrite = 1; regdst = 1;
        tick();
        idle();
        load_ir({OP_RTYPE, 5'd0, 5'd12, 5'd0, 5'd0, 6'h20});
        tick();
        n_tests++; if (writedata !== 32'h1234) begin $display("FAIL rtype_rd got=%h exp=%h", writedata, 32'h1234); n_fail++; end
        load_ir({OP_RTYPE, 5'd0, 5'd3, 5'd0, 5'd0, 6'h20});
        tick();
        n_tests++; if (writedata !== 32'h1235) begin $display("FAIL rtype_rt_kept got=%h exp=%h", writedata, 32'h1235); n_fail++; end
    endtask

    task automatic test_jump_and_load();
        reset = 1; #1; reset = 0;
        idle();
        readdata = 32'h08000010; irwrite = 1; pcen = 1; alusrcb = SRCB_FOUR;
        tick();
        n_tests++; if (opcode !== OP_J) begin $display("FAIL jump_opcode got=%b exp=%b", opcode, OP_J); n_fail++; end
        idle(); pcsrc = PCSRC_JUMP; pcen = 1;
        tick();
        n_tests++; if (adr !== 32'h40) begin $display("FAIL jump_pc got=%h exp=%h", adr, 32'h40); n_fail++; end
        pcsrc = 2'b11; alusrca = 0; alusrcb = SRCB_IMM;
        tick();
        n_tests++; if (adr !== 32'h50) begin $display("FAIL pcsrc11_pc got=%h exp=%h", adr, 32'h50); n_fail++; end
        pcen = 0; alusrcb = SRCB_FOUR;
        tick();
        pcen = 1; pcsrc = PCSRC_ALUOUT; alusrcb = SRCB_IMM;
        tick();
        n_tests++; if (adr !== 32'h54) begin $display("FAIL pcsrc01_pc got=%h exp=%h", adr, 32'h54); n_fail++; end
        idle();
        load_ir(32'h8C070020);
        tick();
        alusrca = 1; alusrcb = SRCB_IMM; alucontrol = ALU_ADD;
        tick();
        iord = 1; #1;
        n_tests++; if (adr !== 32'h20) begin $display("FAIL load_adr got=%h exp=%h", adr, 32'h20); n_fail++; end
        readdata = 32'hCAFEF00D;
        tick();
        memtoreg = 1; regwrite = 1; regdst = 0;
        tick();
        idle();
        load_ir({OP_RTYPE, 5'd7, 5'd7, 5'd0, 5'd0, 6'h20});
        tick();
        n_tests++; if (writedata !== 32'hCAFEF00D) begin $display("FAIL load_wb got=%h exp=%h", writedata, 32'hCAFEF00D); n_fail++; end
    endtask

    initial begin
        test_reset();
        test_reset_during_op();
        test_fetch();
        test_writeback();
        test_rf_old_value();
        test_branch_compare();
        test_slt_and_rtype();
        test_jump_and_load();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
